// File: rtl/ioctl_upload_reader_pkg.sv
// Shared types and constants for the ioctl upload reader.
// Holds the FSM state encoding, the host address width and the out-of-range fill byte.
package ioctl_upload_reader_pkg;

   localparam int unsigned IOCTL_AW = 25;
   localparam logic [7:0]  FILL_BYTE = 8'hFF;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      READY     = 2'd1,
      FETCH     = 2'd2,
      DONE_BYTE = 2'd3
   } state_t;

endpackage

// File: rtl/ioctl_upload_reader.sv
// Serves host ioctl upload reads from a fixed-latency core memory, one byte per request,
// tracking delivered byte count, running checksum and a sticky protocol error.
module ioctl_upload_reader
   import ioctl_upload_reader_pkg::*;
#(
   parameter int unsigned ADDR_W       = 12,
   parameter int unsigned RD_LAT       = 2,
   parameter logic [7:0]  UPLOAD_INDEX = 8'h02
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                ioctl_upload,
   input  logic [7:0]          ioctl_index,
   input  logic                ioctl_rd,
   input  logic [IOCTL_AW-1:0] ioctl_addr,
   output logic [7:0]          ioctl_din,
   output logic                ioctl_wait,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_rd,
   input  logic [7:0]          mem_q,
   output logic [IOCTL_AW-1:0] byte_count,
   output logic [7:0]          checksum,
   output logic                err
);

   state_t     state;
   logic       upload_q;
   logic [2:0] lat_cnt;
   logic       upl_rise;
   logic       upl_fall;
   logic       in_range;

   assign upl_rise = ioctl_upload & ~upload_q;
   assign upl_fall = ~ioctl_upload & upload_q;
   assign in_range = (ioctl_addr >> ADDR_W) == '0;

   // upload_q resets high so an upload already active across reset is not seen as a new session
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         upload_q   <= 1'b1;
         lat_cnt    <= '0;
         ioctl_din  <= '0;
         ioctl_wait <= 1'b0;
         mem_addr   <= '0;
         mem_rd     <= 1'b0;
         byte_count <= '0;
         checksum   <= '0;
         err        <= 1'b0;
      end else begin
         upload_q <= ioctl_upload;
         mem_rd   <= 1'b0;
         if (upl_fall) begin
            // abort beats any concurrent request; results of the session are kept
            state      <= IDLE;
            ioctl_wait <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (upl_rise && ioctl_index == UPLOAD_INDEX) begin
                     state      <= READY;
                     byte_count <= '0;
                     checksum   <= '0;
                     err        <= 1'b0;
                  end
               end
               READY: begin
                  if (ioctl_rd) begin
                     ioctl_wait <= 1'b1;
                     if (in_range) begin
                        mem_addr <= ioctl_addr[ADDR_W-1:0];
                        mem_rd   <= 1'b1;
                        lat_cnt  <= '0;
                        state    <= FETCH;
                     end else begin
                        ioctl_din <= FILL_BYTE;
                        state     <= DONE_BYTE;
                     end
                  end
               end
               FETCH: begin
                  if (ioctl_rd) err <= 1'b1;
                  // lat_cnt reaches RD_LAT on the edge where mem_q holds the requested byte
                  if (lat_cnt == 3'(RD_LAT)) begin
                     ioctl_din <= mem_q;
                     state     <= DONE_BYTE;
                  end else begin
                     lat_cnt <= lat_cnt + 3'd1;
                  end
               end
               DONE_BYTE: begin
                  if (ioctl_rd) err <= 1'b1;
                  ioctl_wait <= 1'b0;
                  byte_count <= byte_count + 1'b1;
                  checksum   <= checksum + ioctl_din;
                  state      <= READY;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Directed bench for ioctl_upload_reader with a 2-cycle-latency memory model.
module tb_ioctl_upload_reader;

   localparam int ADDR_W = 12;
   localparam int RD_LAT = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ioctl_upload;
   logic [7:0]  ioctl_index;
   logic        ioctl_rd;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic [11:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_q;
   logic [24:0] byte_count;
   logic [7:0]  checksum;
   logic        err;

   int checks = 0;
   int errors = 0;
   int rd_cnt = 0;
   int wait_cnt = 0;
   int dbl_cnt = 0;
   logic mem_rd_prev = 1'b0;

   logic [7:0] mem [0:4095];
   logic [7:0] p1 = 8'h00;
   logic [7:0] p2 = 8'h00;

   ioctl_upload_reader #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .UPLOAD_INDEX(8'h02)) dut (
      .clk(clk), .reset_n(reset_n), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
      .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
      .ioctl_wait(ioctl_wait), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_q(mem_q),
      .byte_count(byte_count), .checksum(checksum), .err(err)
   );

   always #5 clk = ~clk;

   // Data is only visible in the single cycle RD_LAT cycles after the strobe
   always @(posedge clk) begin
      p1 <= mem_rd ? mem[mem_addr] : 8'h00;
      p2 <= p1;
   end
   assign mem_q = p2;

   always @(negedge clk) begin
      if (mem_rd) rd_cnt++;
      if (ioctl_wait) wait_cnt++;
      if (mem_rd && mem_rd_prev) dbl_cnt++;
      mem_rd_prev = mem_rd;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_session(input logic [7:0] idx);
      ioctl_upload = 1'b0;
      tick();
      ioctl_index  = idx;
      ioctl_upload = 1'b1;
      tick();
   endtask

   task automatic do_read(input logic [24:0] addr);
      int n;
      n = 0;
      ioctl_rd   = 1'b1;
      ioctl_addr = addr;
      tick();
      ioctl_rd = 1'b0;
      while (ioctl_wait && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL read_timeout addr=%h wait still %b after %0d cycles", addr, ioctl_wait, n);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      ioctl_upload = 1'b0; ioctl_index = 8'h00; ioctl_rd = 1'b0; ioctl_addr = '0;
      tick(); tick();
      checks++;
      if ({ioctl_din, ioctl_wait, mem_rd, mem_addr, byte_count, checksum, err} !== '0) begin
         errors++;
         $display("FAIL reset_state din=%h wait=%b rd=%b addr=%h bc=%h cs=%h err=%b expected all 0",
                  ioctl_din, ioctl_wait, mem_rd, mem_addr, byte_count, checksum, err);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      start_session(8'h02);
      rd_cnt = 0; wait_cnt = 0;
      do_read(25'h10);
      checks++; if (rd_cnt !== 1) begin errors++; $display("FAIL single_mem_rd got %0d expected 1", rd_cnt); end
      checks++; if (wait_cnt !== 4) begin errors++; $display("FAIL single_wait got %0d expected 4", wait_cnt); end
      checks++; if (ioctl_din !== 8'hA5) begin errors++; $display("FAIL single_din got %h expected a5", ioctl_din); end
      checks++; if (byte_count !== 25'd1) begin errors++; $display("FAIL single_bc got %0d expected 1", byte_count); end
      checks++; if (checksum !== 8'hA5) begin errors++; $display("FAIL single_cs got %h expected a5", checksum); end
   endtask

   task automatic test_multi();
      start_session(8'h02);
      checks++;
      if (byte_count !== 25'd0 || checksum !== 8'h00) begin
         errors++; $display("FAIL session_clear bc=%0d cs=%h expected 0 00", byte_count, checksum);
      end
      for (int a = 0; a < 4; a++) do_read(25'(a));
      checks++; if (byte_count !== 25'd4) begin errors++; $display("FAIL multi_bc got %0d expected 4", byte_count); end
      checks++; if (checksum !== 8'h30) begin errors++; $display("FAIL multi_cs got %h expected 30", checksum); end
      checks++; if (ioctl_din !== 8'h20) begin errors++; $display("FAIL multi_din got %h expected 20", ioctl_din); end
   endtask

   task automatic test_oob();
      rd_cnt = 0; wait_cnt = 0;
      do_read(25'h1000);
      checks++; if (rd_cnt !== 0) begin errors++; $display("FAIL oob_mem_rd got %0d expected 0", rd_cnt); end
      checks++; if (ioctl_din !== 8'hFF) begin errors++; $display("FAIL oob_din got %h expected ff", ioctl_din); end
      checks++; if (wait_cnt !== 1) begin errors++; $display("FAIL oob_wait got %0d expected 1", wait_cnt); end
      checks++; if (byte_count !== 25'd5) begin errors++; $display("FAIL oob_bc got %0d expected 5", byte_count); end
      checks++; if (checksum !== 8'h2F) begin errors++; $display("FAIL oob_cs got %h expected 2f", checksum); end
   endtask

   task automatic test_err();
      int n;
      start_session(8'h02);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b expected 0", err); end
      rd_cnt = 0;
      ioctl_rd = 1'b1; ioctl_addr = 25'h20;
      tick();
      ioctl_addr = 25'h21;
      tick();
      ioctl_rd = 1'b0;
      n = 0;
      while (ioctl_wait && n < 20) begin tick(); n++; end
      checks++; if (n >= 20) begin errors++; $display("FAIL err_timeout wait=%b expected 0", ioctl_wait); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_flag got %b expected 1", err); end
      checks++; if (rd_cnt !== 1) begin errors++; $display("FAIL err_mem_rd got %0d expected 1", rd_cnt); end
      checks++; if (ioctl_din !== 8'h5A) begin errors++; $display("FAIL err_din got %h expected 5a", ioctl_din); end
      checks++; if (byte_count !== 25'd1) begin errors++; $display("FAIL err_bc got %0d expected 1", byte_count); end
   endtask

   task automatic test_abort();
      start_session(8'h02);
      rd_cnt = 0;
      ioctl_rd = 1'b1; ioctl_addr = 25'h30;
      tick();
      ioctl_rd = 1'b0;
      tick();
      ioctl_upload = 1'b0;
      tick();
      checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL abort_wait got %b expected 0", ioctl_wait); end
      for (int i = 0; i < 5; i++) tick();
      checks++; if (byte_count !== 25'd0) begin errors++; $display("FAIL abort_bc got %0d expected 0", byte_count); end
      checks++; if (rd_cnt !== 1) begin errors++; $display("FAIL abort_mem_rd got %0d expected 1", rd_cnt); end
      checks++; if (ioctl_din !== 8'h5A) begin errors++; $display("FAIL abort_din_hold got %h expected 5a", ioctl_din); end
   endtask

   task automatic test_abort_same_cycle();
      start_session(8'h02);
      rd_cnt = 0; wait_cnt = 0;
      ioctl_upload = 1'b0; ioctl_rd = 1'b1; ioctl_addr = 25'h10;
      tick();
      ioctl_rd = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (rd_cnt !== 0 || wait_cnt !== 0 || err !== 1'b0 || byte_count !== 25'd0) begin
         errors++;
         $display("FAIL abort_same_cycle rd=%0d wait=%0d err=%b bc=%0d expected 0 0 0 0",
                  rd_cnt, wait_cnt, err, byte_count);
      end
   endtask

   task automatic test_bad_index();
      start_session(8'h05);
      rd_cnt = 0; wait_cnt = 0;
      ioctl_rd = 1'b1; ioctl_addr = 25'h10;
      tick();
      ioctl_rd = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      checks++; if (rd_cnt !== 0) begin errors++; $display("FAIL bad_index_mem_rd got %0d expected 0", rd_cnt); end
      checks++; if (wait_cnt !== 0) begin errors++; $display("FAIL bad_index_wait got %0d expected 0", wait_cnt); end
   endtask

   task automatic test_reset_mid_fetch();
      start_session(8'h02);
      do_read(25'h10);
      ioctl_rd = 1'b1; ioctl_addr = 25'h20;
      tick();
      tick();
      ioctl_rd = 1'b0;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({ioctl_din, ioctl_wait, mem_rd, mem_addr, byte_count, checksum, err} !== '0) begin
         errors++;
         $display("FAIL reset_mid_fetch din=%h wait=%b rd=%b addr=%h bc=%h cs=%h err=%b expected all 0",
                  ioctl_din, ioctl_wait, mem_rd, mem_addr, byte_count, checksum, err);
      end
      tick();
      reset_n = 1'b1;
      tick(); tick();
      rd_cnt = 0; wait_cnt = 0;
      ioctl_rd = 1'b1; ioctl_addr = 25'h10;
      tick();
      ioctl_rd = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      checks++;
      if (rd_cnt !== 0 || wait_cnt !== 0) begin
         errors++;
         $display("FAIL post_reset_idle mem_rd=%0d wait=%0d expected 0 0", rd_cnt, wait_cnt);
      end
      ioctl_upload = 1'b0;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      mem[12'h000] = 8'hFF; mem[12'h001] = 8'h01; mem[12'h002] = 8'h10; mem[12'h003] = 8'h20;
      mem[12'h010] = 8'hA5; mem[12'h020] = 8'h5A; mem[12'h021] = 8'h77; mem[12'h030] = 8'h3C;

      test_reset();
      test_single();
      test_multi();
      test_oob();
      test_err();
      test_abort();
      test_abort_same_cycle();
      test_bad_index();
      test_reset_mid_fetch();

      checks++;
      if (dbl_cnt !== 0) begin errors++; $display("FAIL mem_rd_single_cycle got %0d doubles expected 0", dbl_cnt); end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ioctl_upload_reader.md
IOCTL_UPLOAD_READER -- requirements
Module: ioctl_upload_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning width of the core memory address (4 KB image).
REQ-002 SHALL have parameter RD_LAT, default 2, range 1..7, meaning fixed memory read latency in clk cycles from mem_rd to valid mem_q.
REQ-003 SHALL have parameter UPLOAD_INDEX, default 8'h02, meaning the ioctl_index value this block serves.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 ioctl_upload  in  1  host upload session active.
REQ-007 ioctl_index  in  8  image selector, sampled on ioctl_upload rising edge.
REQ-008 ioctl_rd  in  1  single-cycle host request for the byte at ioctl_addr.
REQ-009 ioctl_addr  in  25  byte address of the request.
REQ-010 ioctl_din  out  8  byte returned to the host.
REQ-011 ioctl_wait  out  1  high while a request is in progress; host holds off.
REQ-012 mem_addr  out  ADDR_W  read address to core memory.
REQ-013 mem_rd  out  1  single-cycle memory read strobe.
REQ-014 mem_q  in  8  memory read data, valid RD_LAT cycles after mem_rd.
REQ-015 byte_count  out  25  bytes delivered in the current session.
REQ-016 checksum  out  8  modulo-256 sum of bytes delivered in the current session.
REQ-017 err  out  1  sticky protocol error flag.

Function
REQ-018 SHALL use states IDLE, READY, FETCH, DONE_BYTE.
REQ-019 IDLE -> READY when ioctl_upload rises while ioctl_index == UPLOAD_INDEX; this clears byte_count, checksum and err.
REQ-020 A rising ioctl_upload with a non-matching index SHALL leave the block in IDLE; ioctl_rd is ignored in IDLE and ioctl_wait stays 0.
REQ-021 In READY, ioctl_rd with ioctl_addr < 2**ADDR_W SHALL drive mem_addr = ioctl_addr[ADDR_W-1:0] and pulse mem_rd in the next cycle, set ioctl_wait = 1 in that same cycle, and enter FETCH.
REQ-022 FETCH SHALL count RD_LAT cycles after mem_rd, then capture mem_q into ioctl_din and enter DONE_BYTE.
REQ-023 In READY, ioctl_rd with ioctl_addr >= 2**ADDR_W SHALL not pulse mem_rd; it SHALL load ioctl_din = 8'hFF, hold ioctl_wait = 1 for exactly one cycle, and enter DONE_BYTE.
REQ-024 DONE_BYTE SHALL drop ioctl_wait to 0, increment byte_count (25-bit, wraps), add ioctl_din to checksum (8-bit, wraps), and return to READY in one cycle.
REQ-025 In-range request latency, ioctl_rd to ioctl_wait low, SHALL be RD_LAT + 2 cycles.
REQ-026 ioctl_rd while ioctl_wait = 1 or in DONE_BYTE SHALL be ignored and SHALL set err.
REQ-027 ioctl_upload falling in any state SHALL return to IDLE next cycle, abort any fetch with no further mem_rd, force ioctl_wait = 0, and hold ioctl_din, byte_count, checksum and err.
REQ-028 ioctl_upload falling and ioctl_rd in the same cycle: the abort wins, and the request is neither served nor flagged.
REQ-029 mem_rd SHALL never be high for more than one consecutive cycle.

Reset
REQ-030 reset_n low SHALL asynchronously force IDLE, ioctl_din = 0, ioctl_wait = 0, mem_rd = 0, mem_addr = 0, byte_count = 0, checksum = 0, err = 0, and clear the latency counter.
REQ-031 Reset asserted mid-FETCH SHALL discard the pending byte; after release the block waits for a new ioctl_upload rising edge.

Structure
REQ-032 A shared package SHALL hold the state enum, the 25-bit ioctl address width constant and the 8'hFF fill constant.
REQ-033 The block SHALL be a single module with no sub-module; the latency counter is inline, 3 bits wide.

Verification
REQ-034 With RD_LAT = 2 and mem[0x010] = 0xA5, upload on index 0x02 and rd at addr 0x10 -> mem_rd one cycle, ioctl_wait high for 4 cycles, ioctl_din = 0xA5, byte_count = 1, checksum = 0xA5.
REQ-035 Read addresses 0..3 holding 0xFF, 0x01, 0x10, 0x20 -> byte_count = 4, checksum = 0x30 (wrapped).
REQ-036 rd at addr 0x1000 -> no mem_rd, ioctl_din = 0xFF, ioctl_wait high for one cycle.
REQ-037 Second rd while ioctl_wait = 1 -> err = 1, exactly one mem_rd, first byte delivered correctly.
REQ-038 Drop ioctl_upload one cycle after mem_rd -> IDLE, ioctl_wait = 0, byte_count unchanged; reset_n pulsed mid-FETCH -> all outputs 0.
REQ-039 Upload on index 0x05 followed by rd -> no mem_rd, ioctl_wait stays 0.
